// File: rtl/alu_pipe_arbiter.sv
// Round-robin front end sharing one add/sub pipeline between two requesters.
// Credits guarantee every issued result has a free response FIFO slot.
module alu_pipe_arbiter #(
  parameter int DWIDTH     = 8,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [DWIDTH-1:0] req0_op1_i,
  input  logic [DWIDTH-1:0] req0_op2_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [DWIDTH-1:0] req1_op1_i,
  input  logic [DWIDTH-1:0] req1_op2_i,
  output logic              resp0_valid_o,
  input  logic              resp0_ready_i,
  output logic [DWIDTH-1:0] resp0_data_o,
  output logic              resp1_valid_o,
  input  logic              resp1_ready_i,
  output logic [DWIDTH-1:0] resp1_data_o,
  output logic [DWIDTH-1:0] pipe_op1_o,
  output logic [DWIDTH-1:0] pipe_op2_o,
  input  logic [DWIDTH-1:0] pipe_res_i,
  output logic              busy_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(FIFO_DEPTH);
  localparam logic [CW-1:0] CNT_INC    = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   PTR_INC    = {{AW{1'b0}}, 1'b1};

  logic [1:0]         req_valid_s, resp_ready_s, elig_s, grant_s;
  logic [1:0]         push_s, pop_s, empty_s, full_s;
  logic               prio_r;
  logic [CW-1:0]      out_r [2];
  logic [LATENCY-1:0] tag_v_r, tag_id_r;
  logic [DWIDTH-1:0]  mem_r [2][FIFO_DEPTH];
  logic [AW:0]        wr_ptr_r [2];
  logic [AW:0]        rd_ptr_r [2];
  logic [DWIDTH-1:0]  head_s [2];

  assign req_valid_s  = {req1_valid_i, req0_valid_i};
  assign resp_ready_s = {resp1_ready_i, resp0_ready_i};
  assign elig_s[0]    = req_valid_s[0] && (out_r[0] < CREDIT_MAX);
  assign elig_s[1]    = req_valid_s[1] && (out_r[1] < CREDIT_MAX);

  // Arbiter: a lone eligible requester always wins; ties go to the pointer.
  always_comb begin
    grant_s = 2'b00;
    if (!rst) begin
      grant_s = 2'b00;
    end else if (elig_s == 2'b11) begin
      grant_s = prio_r ? 2'b10 : 2'b01;
    end else begin
      grant_s = elig_s;
    end
  end

  assign req0_ready_o = grant_s[0];
  assign req1_ready_o = grant_s[1];

  // Issue mux: granted operands go straight to the pipeline, zeros when idle.
  always_comb begin
    pipe_op1_o = '0;
    pipe_op2_o = '0;
    if (grant_s[0]) begin
      pipe_op1_o = req0_op1_i;
      pipe_op2_o = req0_op2_i;
    end else if (grant_s[1]) begin
      pipe_op1_o = req1_op1_i;
      pipe_op2_o = req1_op2_i;
    end else begin
      pipe_op1_o = '0;
      pipe_op2_o = '0;
    end
  end

  // Priority pointer hands priority to the other requester after each grant.
  always_ff @(posedge clk) begin
    if (!rst) begin
      prio_r <= 1'b0;
    end else if (grant_s[0]) begin
      prio_r <= 1'b1;
    end else if (grant_s[1]) begin
      prio_r <= 1'b0;
    end else begin
      prio_r <= prio_r;
    end
  end

  // Tag pipe mirrors the ALU latency so each result knows its owner.
  always_ff @(posedge clk) begin
    if (!rst) begin
      tag_v_r  <= '0;
      tag_id_r <= '0;
    end else begin
      tag_v_r[0]  <= |grant_s;
      tag_id_r[0] <= grant_s[1];
      for (int i = 1; i < LATENCY; i++) begin
        tag_v_r[i]  <= tag_v_r[i-1];
        tag_id_r[i] <= tag_id_r[i-1];
      end
    end
  end

  assign push_s[0] = tag_v_r[LATENCY-1] & ~tag_id_r[LATENCY-1];
  assign push_s[1] = tag_v_r[LATENCY-1] &  tag_id_r[LATENCY-1];

  // Outstanding-credit counters: grant takes a credit, pop returns it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      out_r[0] <= '0;
      out_r[1] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        case ({grant_s[k], pop_s[k]})
          2'b10:   out_r[k] <= out_r[k] + CNT_INC;
          2'b01:   out_r[k] <= out_r[k] - CNT_INC;
          default: out_r[k] <= out_r[k];
        endcase
      end
    end
  end

  // Response FIFO pointers; the extra MSB separates full from empty.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        wr_ptr_r[k] <= '0;
        rd_ptr_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        wr_ptr_r[k] <= push_s[k] ? wr_ptr_r[k] + PTR_INC : wr_ptr_r[k];
        rd_ptr_r[k] <= pop_s[k]  ? rd_ptr_r[k] + PTR_INC : rd_ptr_r[k];
      end
    end
  end

  // FIFO storage needs no reset; emptiness is tracked by the pointers.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (push_s[k]) begin
        mem_r[k][wr_ptr_r[k][AW-1:0]] <= pipe_res_i;
      end
    end
  end

  always_comb begin
    for (int k = 0; k < 2; k++) begin
      empty_s[k] = (wr_ptr_r[k] == rd_ptr_r[k]);
      full_s[k]  = (wr_ptr_r[k][AW] != rd_ptr_r[k][AW]) &&
                   (wr_ptr_r[k][AW-1:0] == rd_ptr_r[k][AW-1:0]);
      pop_s[k]   = ~empty_s[k] & resp_ready_s[k];
      head_s[k]  = empty_s[k] ? '0 : mem_r[k][rd_ptr_r[k][AW-1:0]];
    end
  end

  assign resp0_valid_o = ~empty_s[0];
  assign resp1_valid_o = ~empty_s[1];
  assign resp0_data_o  = head_s[0];
  assign resp1_data_o  = head_s[1];
  assign busy_o        = (|tag_v_r) | ~empty_s[0] | ~empty_s[1];

  alu_pipe_arbiter_chk u_chk (
    .clk   (clk),
    .rst   (rst),
    .grant (grant_s),
    .push  (push_s),
    .pop   (pop_s),
    .full  (full_s)
  );
endmodule

module alu_pipe_arbiter_chk (
  input logic       clk,
  input logic       rst,
  input logic [1:0] grant,
  input logic [1:0] push,
  input logic [1:0] pop,
  input logic [1:0] full
);
  // A push may only land on a full FIFO when a pop frees the head that cycle.
  push_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    ((push & full & ~pop) == 2'b00));
  single_grant: assert property (@(posedge clk) disable iff (!rst) $onehot0(grant));
endmodule

// File: tb/tb_alu_pipe_arbiter.sv
// Directed bench for alu_pipe_arbiter with an add-then-subtract pipeline model
// and per-requester scoreboards of expected response data.
module tb_alu_pipe_arbiter;
  localparam int LAT = 3;

  logic       clk = 1'b0;
  logic       rst;
  logic       req0_valid_i, req1_valid_i, req0_ready_o, req1_ready_o;
  logic [7:0] req0_op1_i, req0_op2_i, req1_op1_i, req1_op2_i;
  logic       resp0_valid_o, resp1_valid_o, resp0_ready_i, resp1_ready_i;
  logic [7:0] resp0_data_o, resp1_data_o;
  logic [7:0] pipe_op1_o, pipe_op2_o, pipe_res_i;
  logic       busy_o;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  logic       s_ready0, s_ready1, s_rv0, s_rv1, s_busy;
  logic [7:0] s_op1, s_op2;
  logic [7:0] p1_q [LAT];
  logic [7:0] p2_q [LAT];

  alu_pipe_arbiter #(.DWIDTH(8), .LATENCY(LAT), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o),
    .req0_op1_i(req0_op1_i), .req0_op2_i(req0_op2_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o),
    .req1_op1_i(req1_op1_i), .req1_op2_i(req1_op2_i),
    .resp0_valid_o(resp0_valid_o), .resp0_ready_i(resp0_ready_i), .resp0_data_o(resp0_data_o),
    .resp1_valid_o(resp1_valid_o), .resp1_ready_i(resp1_ready_i), .resp1_data_o(resp1_data_o),
    .pipe_op1_o(pipe_op1_o), .pipe_op2_o(pipe_op2_o), .pipe_res_i(pipe_res_i),
    .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  // Add-then-subtract pipeline, reset together with the arbiter.
  always @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < LAT; i++) begin
        p1_q[i] <= 8'h00;
        p2_q[i] <= 8'h00;
      end
    end else begin
      p1_q[0] <= pipe_op1_o;
      p2_q[0] <= pipe_op2_o;
      for (int i = 1; i < LAT; i++) begin
        p1_q[i] <= p1_q[i-1];
        p2_q[i] <= p2_q[i-1];
      end
    end
  end
  assign pipe_res_i = p1_q[LAT-1] + p2_q[LAT-1] - p1_q[LAT-1];

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (cyc > 3000) begin
      $display("FAIL timeout observed=%0d cycles expected<=3000", cyc);
      $fatal(1, "bench timeout");
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample one cycle mid-period, update scoreboards, then step past the edge.
  task automatic tick();
    logic [7:0] e;
    @(negedge clk);
    s_ready0 = req0_ready_o;
    s_ready1 = req1_ready_o;
    s_rv0    = resp0_valid_o;
    s_rv1    = resp1_valid_o;
    s_busy   = busy_o;
    s_op1    = pipe_op1_o;
    s_op2    = pipe_op2_o;
    if (s_ready0) exp0.push_back(req0_op2_i);
    if (s_ready1) exp1.push_back(req1_op2_i);
    if (resp0_valid_o && resp0_ready_i) begin
      if (exp0.size() == 0) chk("resp0_unexpected", 32'd1, 32'd0);
      else begin
        e = exp0.pop_front();
        chk("resp0_data", resp0_data_o, e);
      end
    end
    if (resp1_valid_o && resp1_ready_i) begin
      if (exp1.size() == 0) chk("resp1_unexpected", 32'd1, 32'd0);
      else begin
        e = exp1.pop_front();
        chk("resp1_data", resp1_data_o, e);
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    req0_op1_i = 8'h11; req0_op2_i = 8'h22; req1_op1_i = 8'h33; req1_op2_i = 8'h44;
    resp0_ready_i = 1'b1; resp1_ready_i = 1'b1;

    // Reset held with both requesters asking
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ready0", s_ready0, 1'b0);
      chk("rst_ready1", s_ready1, 1'b0);
      chk("rst_rvalid", {s_rv0, s_rv1}, 2'b00);
      chk("rst_pipe_op", {s_op1, s_op2}, 16'h0000);
      chk("rst_busy", s_busy, 1'b0);
    end
    rst = 1'b1; req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    tick();

    // Fairness: both valid, alternating grants starting with requester 0
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req0_op1_i = 8'(i * 3);      req0_op2_i = 8'(i * 16 + 1);
      req1_op1_i = 8'(i * 5 + 7);  req1_op2_i = 8'(i * 16 + 9);
      tick();
      chk("fair_grant0", s_ready0, (i % 2) == 0);
      chk("fair_grant1", s_ready1, (i % 2) == 1);
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("fair_drain0", exp0.size(), 0);
    chk("fair_drain1", exp1.size(), 0);
    chk("fair_idle_busy", s_busy, 1'b0);

    // Single op: response appears exactly LAT+1 cycles after acceptance
    req0_valid_i = 1'b1; req0_op1_i = 8'd5; req0_op2_i = 8'd3;
    tick();
    chk("single_ready0", s_ready0, 1'b1);
    chk("single_op1", s_op1, 8'd5);
    chk("single_op2", s_op2, 8'd3);
    req0_valid_i = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      tick();
      chk("single_rvalid", s_rv0, c == 4);
      chk("single_busy", s_busy, c <= 4);
      if (c != 4) chk("single_idle_op", s_op1, 8'd0);
    end

    // Credit stall: only four grants without consumption
    resp0_ready_i = 1'b0; req0_valid_i = 1'b1;
    for (int i = 0; i < 8; i++) begin
      req0_op1_i = 8'(i + 100); req0_op2_i = 8'(8'hA0 + i);
      tick();
      chk("stall_ready0", s_ready0, i < 4);
    end
    chk("stall_full_valid", s_rv0, 1'b1);
    req0_op2_i = 8'hC5;
    resp0_ready_i = 1'b1;
    tick();
    chk("pulse_ready0", s_ready0, 1'b0);
    resp0_ready_i = 1'b0;
    tick();
    chk("pulse_regrant", s_ready0, 1'b1);
    req0_op2_i = 8'hD7;
    tick();
    chk("pulse_reblock", s_ready0, 1'b0);

    // Requester 0 out of credit: requester 1 wins regardless of pointer
    req1_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      req1_op1_i = 8'(i + 40); req1_op2_i = 8'(8'h50 + i);
      tick();
      chk("blocked_ready1", s_ready1, 1'b1);
      chk("blocked_ready0", s_ready0, 1'b0);
    end
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; resp0_ready_i = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    chk("credit_drain0", exp0.size(), 0);
    chk("credit_drain1", exp1.size(), 0);
    chk("credit_busy", s_busy, 1'b0);

    // Mid-flight reset discards two in-flight operations
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    req0_op2_i = 8'hE1; req1_op2_i = 8'hE2;
    tick();
    chk("mid_grant0", s_ready0, 1'b1);
    tick();
    chk("mid_grant1", s_ready1, 1'b1);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0; rst = 1'b0;
    tick();
    exp0.delete(); exp1.delete();
    rst = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      chk("mid_no_resp", {s_rv0, s_rv1}, 2'b00);
      chk("mid_busy", s_busy, 1'b0);
    end
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    req0_op2_i = 8'h61; req1_op2_i = 8'h62;
    tick();
    chk("post_rst_grant0", s_ready0, 1'b1);
    chk("post_rst_grant1", s_ready1, 1'b0);
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    for (int i = 0; i < 8; i++) tick();
    chk("final_drain0", exp0.size(), 0);
    chk("final_drain1", exp1.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
